// File: rtl/morse_pkg.sv
// Shared constants for the Morse letter decoder: symbol limits, letter patterns,
// letter codes and the control state encoding.
package morse_pkg;

  localparam int MORSE_LEN = 13;

  // Patterns are left-justified symbol streams (dot=1, dash=111, gap=0), zero-filled.
  localparam logic [12:0] PAT_S = 13'b1010100000000;
  localparam logic [12:0] PAT_T = 13'b1110000000000;
  localparam logic [12:0] PAT_U = 13'b1010111000000;
  localparam logic [12:0] PAT_V = 13'b1010101110000;
  localparam logic [12:0] PAT_W = 13'b1011101110000;
  localparam logic [12:0] PAT_X = 13'b1110101011100;
  localparam logic [12:0] PAT_Y = 13'b1110101110111;
  localparam logic [12:0] PAT_Z = 13'b1110111010100;

  localparam logic [2:0] LTR_S = 3'd0;
  localparam logic [2:0] LTR_T = 3'd1;
  localparam logic [2:0] LTR_U = 3'd2;
  localparam logic [2:0] LTR_V = 3'd3;
  localparam logic [2:0] LTR_W = 3'd4;
  localparam logic [2:0] LTR_X = 3'd5;
  localparam logic [2:0] LTR_Y = 3'd6;
  localparam logic [2:0] LTR_Z = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

endpackage

// File: rtl/morse_lookup.sv
// Combinational match of a completed symbol pattern against the letter table.
module morse_lookup
  import morse_pkg::*;
(
  input  logic [12:0] pattern,
  output logic [2:0]  letter,
  output logic        hit
);

  always_comb begin
    letter = LTR_S;
    hit    = 1'b1;
    case (pattern)
      PAT_S:   letter = LTR_S;
      PAT_T:   letter = LTR_T;
      PAT_U:   letter = LTR_U;
      PAT_V:   letter = LTR_V;
      PAT_W:   letter = LTR_W;
      PAT_X:   letter = LTR_X;
      PAT_Y:   letter = LTR_Y;
      PAT_Z:   letter = LTR_Z;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Serial Morse decoder: collects tick-qualified symbols into a pattern, closes a
// letter after GAP_LEN spaces and reports the decoded letter or an error.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int GAP_LEN   = 3,
  parameter int MORSE_LEN = morse_pkg::MORSE_LEN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic [7:0] rx_count
);

  localparam logic [3:0] CNT_MAX  = 4'(MORSE_LEN);
  localparam logic [2:0] GAP_LAST = 3'(GAP_LEN - 1);

  state_t      state, state_next;
  logic [12:0] pat, pat_next;
  logic [3:0]  cnt, cnt_next;
  logic [2:0]  zero_run, zero_run_next;
  logic [2:0]  letter_next;
  logic        letter_valid_next, error_next;
  logic [7:0]  rx_count_next;
  logic [2:0]  lookup_letter;
  logic        lookup_hit;

  // Pattern bits past cnt are still zero from the clear at letter start, so the
  // registered pat already equals the completed pattern on the closing tick.
  morse_lookup u_lookup (
    .pattern (pat),
    .letter  (lookup_letter),
    .hit     (lookup_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pat          <= '0;
      cnt          <= '0;
      zero_run     <= '0;
      letter       <= LTR_S;
      letter_valid <= 1'b0;
      error        <= 1'b0;
      rx_count     <= '0;
    end else begin
      state        <= state_next;
      pat          <= pat_next;
      cnt          <= cnt_next;
      zero_run     <= zero_run_next;
      letter       <= letter_next;
      letter_valid <= letter_valid_next;
      error        <= error_next;
      rx_count     <= rx_count_next;
    end
  end

  always_comb begin
    state_next        = state;
    pat_next          = pat;
    cnt_next          = cnt;
    zero_run_next     = zero_run;
    letter_next       = letter;
    letter_valid_next = 1'b0;
    error_next        = 1'b0;
    rx_count_next     = rx_count;

    if (tick) begin
      case (state)
        IDLE: begin
          if (morse_in) begin
            pat_next      = 13'b1_0000_0000_0000;
            cnt_next      = 4'd1;
            zero_run_next = '0;
            state_next    = COLLECT;
          end
        end

        COLLECT: begin
          if (morse_in) begin
            zero_run_next = '0;
            if (cnt < CNT_MAX) begin
              if (cnt < 4'd13) pat_next[4'd12 - cnt] = 1'b1;
              cnt_next = cnt + 4'd1;
            end else begin
              error_next = 1'b1;
              state_next = DRAIN;
            end
          end else begin
            if (cnt < CNT_MAX) begin
              if (cnt < 4'd13) pat_next[4'd12 - cnt] = 1'b0;
              cnt_next = cnt + 4'd1;
            end
            zero_run_next = zero_run + 3'd1;
            if (zero_run == GAP_LAST) begin
              state_next = IDLE;
              if (lookup_hit) begin
                letter_next       = lookup_letter;
                letter_valid_next = 1'b1;
                rx_count_next     = rx_count + 8'd1;
              end else begin
                error_next = 1'b1;
              end
            end
          end
        end

        DRAIN: begin
          if (morse_in) begin
            zero_run_next = '0;
          end else begin
            zero_run_next = zero_run + 3'd1;
            if (zero_run == GAP_LAST) state_next = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized self-checking bench for morse_decoder against a symbol-queue model.
module tb_morse_decoder;

  localparam int GAP_LEN   = 3;
  localparam int MORSE_LEN = 13;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       morse_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       error;
  logic [7:0] rx_count;

  int vector_count;
  int miscompare_count;
  int valid_seen;

  string tb_pat [8] = '{"1010100000000", "1110000000000", "1010111000000", "1010101110000",
                        "1011101110000", "1110101011100", "1110101110111", "1110111010100"};

  // Model state: symbols of the letter in progress, plus drain/active flags.
  bit         m_active;
  bit         m_draining;
  bit         sym_q [$];
  int         m_zeros;
  logic [2:0] exp_letter;
  bit         exp_valid;
  bit         exp_error;
  logic [7:0] exp_count;

  morse_decoder #(.GAP_LEN(GAP_LEN), .MORSE_LEN(MORSE_LEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .morse_in     (morse_in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .error        (error),
    .rx_count     (rx_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int decode_queue();
    for (int k = 0; k < 8; k++) begin
      bit same = 1'b1;
      for (int b = 0; b < 13; b++) begin
        bit sym = (b < sym_q.size()) ? sym_q[b] : 1'b0;
        if (sym != (tb_pat[k][b] == 8'h31)) same = 1'b0;
      end
      if (same) return k;
    end
    return -1;
  endfunction

  function automatic void model_step(bit r, bit t, bit m);
    int code;
    exp_valid = 1'b0;
    exp_error = 1'b0;
    if (r) begin
      m_active   = 1'b0;
      m_draining = 1'b0;
      sym_q.delete();
      m_zeros    = 0;
      exp_letter = 3'd0;
      exp_count  = 8'd0;
      return;
    end
    if (!t) return;
    if (m_draining) begin
      m_zeros = m ? 0 : m_zeros + 1;
      if (m_zeros == GAP_LEN) m_draining = 1'b0;
      return;
    end
    if (!m_active) begin
      if (m) begin
        m_active = 1'b1;
        sym_q.delete();
        sym_q.push_back(1'b1);
        m_zeros = 0;
      end
      return;
    end
    if (m) begin
      m_zeros = 0;
      if (sym_q.size() >= MORSE_LEN) begin
        exp_error  = 1'b1;
        m_active   = 1'b0;
        m_draining = 1'b1;
      end else begin
        sym_q.push_back(1'b1);
      end
    end else begin
      sym_q.push_back(1'b0);
      m_zeros++;
      if (m_zeros == GAP_LEN) begin
        m_active = 1'b0;
        code = decode_queue();
        if (code >= 0) begin
          exp_letter = 3'(code);
          exp_valid  = 1'b1;
          exp_count  = exp_count + 8'd1;
        end else begin
          exp_error = 1'b1;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] expv);
    vector_count++;
    if (got !== expv) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit m);
    reset    = r;
    tick     = t;
    morse_in = m;
    @(posedge clock);
    #1;
    model_step(r, t, m);
    valid_seen += int'(letter_valid);
    checkOutput("letter",    16'(letter),       16'(exp_letter));
    checkOutput("valid",     16'(letter_valid), 16'(exp_valid));
    checkOutput("error",     16'(error),        16'(exp_error));
    checkOutput("rx_count",  16'(rx_count),     16'(exp_count));
    checkOutput("exclusive", 16'(letter_valid & error), 16'd0);
  endtask

  task automatic send_string(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b1, s[i] == 8'h31);
    end
  endtask

  function automatic string letter_syms(input int code);
    string p = tb_pat[code];
    int last = 0;
    for (int i = 0; i < p.len(); i++) if (p[i] == 8'h31) last = i;
    return {p.substr(0, last), "000"};
  endfunction

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    valid_seen       = 0;
    reset = 1'b1; tick = 1'b0; morse_in = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);

    send_string("10101000", 1'b0);
    send_string({"1110101110111", "000"}, 1'b0);
    send_string("1000", 1'b0);
    send_string({"11111111111111", "111", "000", "111000"}, 1'b0);

    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'(i));
    send_string("10101", 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    send_string("111000", 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    valid_seen = 0;
    for (int i = 0; i < 256; i++) send_string("10101000", 1'b0);
    checkOutput("s_pulses", 16'(valid_seen), 16'd256);
    checkOutput("s_wrap",   16'(rx_count),   16'd0);

    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 0) begin
        applyStimulus(1'b1, 1'($urandom), 1'($urandom));
      end else if (kind < 6) begin
        send_string(letter_syms($urandom_range(0, 7)), 1'b1);
      end else begin
        string s = "1";
        int len = $urandom_range(0, 15);
        for (int i = 0; i < len; i++) s = {s, ($urandom_range(0, 2) == 0) ? "0" : "1"};
        send_string({s, "000"}, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter: GAP_LEN, default 3, consecutive zero symbols that end a letter (legal 2..7).
REQ-002 Parameter: MORSE_LEN, default 13, maximum symbols per letter, including trailing zeros.
REQ-003 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tick  input  1  one-cycle symbol-rate enable; morse_in is sampled only when tick=1.
REQ-006 Port: morse_in  input  1  serial Morse symbol (1=mark, 0=space); dot=1, dash=111, intra-letter gap=0.
REQ-007 Port: letter  output  3  code of the last decoded letter: S=000, T=001, U=010, V=011, W=100, X=101, Y=110, Z=111.
REQ-008 Port: letter_valid  output  1  one-cycle pulse when letter is updated.
REQ-009 Port: error  output  1  one-cycle pulse on an unrecognised pattern or on overflow.
REQ-010 Port: rx_count  output  8  count of successfully decoded letters.

Function
REQ-011 The block SHALL change no state in a cycle where tick=0, except for clearing the letter_valid and error pulses.
REQ-012 The FSM SHALL have exactly three states: IDLE, COLLECT and DRAIN.
REQ-013 IDLE: on tick with morse_in=0, SHALL stay in IDLE; with morse_in=1, SHALL clear pat[12:0], set pat[12]=1, set cnt=1, set zero_run=0, and enter COLLECT.
REQ-014 COLLECT, tick with morse_in=1 and cnt<MORSE_LEN: SHALL write pat[12-cnt]=1, increment cnt, and clear zero_run.
REQ-015 COLLECT, tick with morse_in=1 and cnt=MORSE_LEN (overflow): SHALL pulse error, clear zero_run, and enter DRAIN.
REQ-016 COLLECT, tick with morse_in=0: SHALL write 0 into pat only if cnt<MORSE_LEN, increment cnt (saturating at MORSE_LEN), and increment zero_run.
REQ-017 In COLLECT, when this tick makes zero_run reach GAP_LEN, the letter is complete and the FSM SHALL return to IDLE.
REQ-018 On a complete letter, pat (left-justified, zero-filled) SHALL be compared against the eight table patterns.
- S=1010100000000, T=1110000000000, U=1010111000000, V=1010101110000
- W=1011101110000, X=1110101011100, Y=1110101110111, Z=1110111010100
REQ-019 On a match, letter, letter_valid and rx_count SHALL all update at the edge that samples the completing tick; letter_valid is high for exactly the following cycle.
REQ-020 On no match, the block SHALL pulse error; letter and rx_count SHALL be unchanged.
REQ-021 DRAIN: on tick with morse_in=1, SHALL clear zero_run; with morse_in=0, SHALL increment zero_run; at GAP_LEN SHALL enter IDLE with no pulse.
REQ-022 letter SHALL hold its value between valid pulses.
REQ-023 rx_count SHALL wrap modulo 256 (255+1 -> 0).
REQ-024 letter_valid and error SHALL never be asserted in the same cycle.

Reset
REQ-025 While reset=1, the state SHALL be IDLE; pat=0, cnt=0, zero_run=0, letter=000, letter_valid=0, error=0, rx_count=0.
REQ-026 Reset SHALL take priority over a coincident tick.
REQ-027 Reset mid-letter SHALL discard partial data with no pulse.

Structure
REQ-028 A shared package morse_pkg SHALL hold:
- MORSE_LEN;
- the eight 13-bit pattern constants;
- the 3-bit letter codes;
- the state enum (IDLE, COLLECT, DRAIN).
REQ-029 Pattern matching SHALL be a combinational sub-module morse_lookup: pattern[12:0] in; letter[2:0] and hit out.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Scenario: reset, then ticks carrying 1,0,1,0,1,0,0,0 -> letter=000, one letter_valid pulse after the 8th tick, rx_count=1.
REQ-032 Scenario: ticks carrying 1110101110111 then 0,0,0 -> letter=110, one letter_valid pulse, no error.
REQ-033 Scenario: ticks carrying 1,0,0,0 (E) -> one error pulse; letter and rx_count unchanged; FSM back in IDLE.
REQ-034 Scenario: 14 consecutive marks -> error at the 14th tick; further marks are ignored; after 0,0,0, a following T (1,1,1,0,0,0) -> letter=001 valid.
REQ-035 Scenario: morse_in toggled with tick=0 -> no output change; reset after 5 bits of V, then T -> no pulse before reset, letter=001 valid, rx_count=1.
REQ-036 Scenario: 256 back-to-back S letters -> rx_count sequence 1..255 then 0; 256 valid pulses.
